neuron_mac_engine: RTL and testbench
====================================

// Module: neuron_mac_engine
// PURPOSE
//  Fabric-side compute engine for the HPS neuron_control PIO bank. On a start edge it fetches
//  kernel_size image words and kernel_size weight words through two Avalon-MM read masters
//  (img / weights), multiply-accumulates them and returns out_neuron/done to the HPS.
//  It also reports its current fetch addresses on addr_img/addr_wei for HPS-side debug.
// PARAMETERS
//  WEI_OFFSET  32'h0001_0000  byte offset of weight vector from base_addr
//  DATA_W      16             signed operand width, taken from readdata[DATA_W-1:0]
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  start          in   1   HPS start level; a 0->1 transition launches a job
//  clear          in   1   HPS clear; zeroes accumulator/out_neuron and drops done
//  kernel_size    in   8   number of image/weight pairs N (0..255)
//  base_addr      in   32  byte address of image word 0
//  done           out  1   job complete; held until clear or next start edge
//  out_neuron     out  32  accumulated result
//  addr_img       out  32  address of current image fetch
//  addr_wei       out  32  address of current weight fetch
//  img_read       out  1   Avalon read, image master
//  img_write      out  1   tied 0
//  img_address    out  32  image byte address
//  img_writedata  out  32  tied 0
//  img_readdata   in   32  image read data
//  img_waitrequest in  1   image slave stall
//  wei_read/wei_write/wei_address/wei_writedata/wei_readdata/wei_waitrequest: same, weight master
// BEHAVIOUR
//  Reset: state IDLE; done=0, out_neuron=0, reads=0, addresses=0, acc=0, index=0, start_q=0.
//  Reset mid-job aborts immediately (reads drop; whole system is reset together).
//  start edge = start & ~start_q, start_q registered each cycle; only honoured in IDLE or DONE.
//  On edge: latch N=kernel_size, B=base_addr; acc<=0, i<=0, done<=0; -> FETCH (N>0) or DONE (N=0).
//  FETCH: img_address=B+4*i, wei_address=B+WEI_OFFSET+4*i (32-bit wrap); addr_img/addr_wei mirror.
//   - img_read and wei_read both asserted; each master independently captures readdata and
//     deasserts its read in the cycle its waitrequest is low (zero-latency Avalon read).
//   - Address/read held stable while waitrequest high. When both captured -> MAC.
//  MAC (1 cycle): acc <= acc + sext32(img[DATA_W-1:0] * wei[DATA_W-1:0]) signed, mod 2^32 wrap.
//   i<=i+1; if i+1==N -> DONE else -> FETCH.
//  DONE: out_neuron<=acc on entry, done=1; stays until clear or new start edge.
//  clear: honoured in IDLE/DONE only -> acc=0, out_neuron=0, done=0, state IDLE; ignored in
//   FETCH/MAC (no Avalon read may be withdrawn under waitrequest). clear & start edge same
//   cycle: clear wins, edge dropped.
//  Latency, zero wait states: start edge sampled cycle 0 -> done=1 in cycle 2N+1 (N=0: cycle 1);
//   each waitrequest cycle on the slower master adds one cycle.
//  start held high after a job does not relaunch; must return low first.
// TESTING
//  N=3, img {2,3,4}, wei {5,6,7}, no waits -> out_neuron=56, done at cycle 7, addr B,B+4,B+8.
//  N=2, img {-3,100}, wei {4,-2}, img_waitrequest high 3 cycles on word 0 -> out=-212, read held, done +3 cycles.
//  N=0 start edge -> done=1 cycle 1, out_neuron=0, no read ever asserted.
//  done=1 then clear pulse -> done=0, out_neuron=0; clear during FETCH -> no effect, job finishes.
//  Start held high across two jobs -> only one job; low-then-high -> second job, acc restarts at 0.
//  reset asserted mid-FETCH with waitrequest high -> next cycle reads=0, done=0, IDLE.

Source files
------------

// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: fetches N image/weight pairs over two Avalon-MM read masters and multiply-accumulates them
module neuron_mac_engine #(
    parameter logic [31:0] WEI_OFFSET = 32'h0001_0000,
    parameter int          DATA_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic [7:0]  kernel_size,
    input  logic [31:0] base_addr,
    output logic        done,
    output logic [31:0] out_neuron,
    output logic [31:0] addr_img,
    output logic [31:0] addr_wei,
    output logic        img_read,
    output logic        img_write,
    output logic [31:0] img_address,
    output logic [31:0] img_writedata,
    input  logic [31:0] img_readdata,
    input  logic        img_waitrequest,
    output logic        wei_read,
    output logic        wei_write,
    output logic [31:0] wei_address,
    output logic [31:0] wei_writedata,
    input  logic [31:0] wei_readdata,
    input  logic        wei_waitrequest
);
    typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;
    state_t state, state_nxt;
    logic start_q, img_got, wei_got, idle_like, wipe, launch, img_ok, wei_ok, last;
    logic [7:0] n_q, idx;
    logic [31:0] acc, acc_nxt;
    logic [DATA_W-1:0] img_data, wei_data;
    logic signed [2*DATA_W-1:0] prod;
    logic unused_bits;
    assign idle_like = state == IDLE || state == DONE;
    assign wipe = idle_like && clear;
    assign launch = idle_like && !clear && start && !start_q;
    assign img_ok = img_got || (img_read && !img_waitrequest);
    assign wei_ok = wei_got || (wei_read && !wei_waitrequest);
    assign last = {1'b0, idx} + 9'd1 == {1'b0, n_q};
    assign prod = $signed(img_data) * $signed(wei_data);
    assign acc_nxt = acc + 32'(prod);
    assign addr_img = img_address;
    assign addr_wei = wei_address;
    assign img_write = 1'b0;
    assign wei_write = 1'b0;
    assign img_writedata = '0;
    assign wei_writedata = '0;
    assign unused_bits = ^{img_readdata[31:DATA_W], wei_readdata[31:DATA_W]};
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: clear beats a simultaneous start edge; FETCH waits for both masters
    always_comb begin
        state_nxt = state;
        if (wipe) state_nxt = IDLE;
        else if (launch) state_nxt = kernel_size == 8'd0 ? DONE : FETCH;
        else if (state == FETCH) state_nxt = img_ok && wei_ok ? MAC : FETCH;
        else if (state == MAC) state_nxt = last ? DONE : FETCH;
    end
    // datapath: read handshakes, operand capture, accumulation and result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            done <= 1'b0;
            out_neuron <= '0;
            acc <= '0;
            idx <= '0;
            n_q <= '0;
            img_read <= 1'b0;
            wei_read <= 1'b0;
            img_got <= 1'b0;
            wei_got <= 1'b0;
            img_address <= '0;
            wei_address <= '0;
            img_data <= '0;
            wei_data <= '0;
        end else begin
            start_q <= start;
            if (wipe) begin
                acc <= '0;
                out_neuron <= '0;
                done <= 1'b0;
            end else if (launch) begin
                n_q <= kernel_size;
                acc <= '0;
                idx <= '0;
                done <= kernel_size == 8'd0;
                out_neuron <= kernel_size == 8'd0 ? 32'd0 : out_neuron;
                img_address <= base_addr;
                wei_address <= base_addr + WEI_OFFSET;
                img_read <= |kernel_size;
                wei_read <= |kernel_size;
                img_got <= 1'b0;
                wei_got <= 1'b0;
            end else if (state == FETCH) begin
                if (img_read && !img_waitrequest) begin
                    img_data <= img_readdata[DATA_W-1:0];
                    img_read <= 1'b0;
                    img_got <= 1'b1;
                end
                if (wei_read && !wei_waitrequest) begin
                    wei_data <= wei_readdata[DATA_W-1:0];
                    wei_read <= 1'b0;
                    wei_got <= 1'b1;
                end
            end else if (state == MAC) begin
                acc <= acc_nxt;
                idx <= idx + 8'd1;
                img_got <= 1'b0;
                wei_got <= 1'b0;
                if (last) begin
                    out_neuron <= acc_nxt;
                    done <= 1'b1;
                end else begin
                    img_read <= 1'b1;
                    wei_read <= 1'b1;
                    img_address <= img_address + 32'd4;
                    wei_address <= wei_address + 32'd4;
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_engine.sv
// tb_neuron_mac_engine: directed vectors and corner sequences for neuron_mac_engine
module tb_neuron_mac_engine;
    localparam logic [31:0] OFF = 32'h0001_0000;
    logic clk = 1'b0;
    logic reset, start, clear;
    logic [7:0] kernel_size;
    logic [31:0] base_addr;
    logic done;
    logic [31:0] out_neuron, addr_img, addr_wei;
    logic img_read, img_write, img_waitrequest, wei_read, wei_write, wei_waitrequest;
    logic [31:0] img_address, img_writedata, img_readdata, wei_address, wei_writedata, wei_readdata;
    typedef struct {
        logic [7:0]  n;
        logic [31:0] base;
        logic [15:0] img [4];
        logic [15:0] wei [4];
        int          wimg;
        int          wwei;
        logic [31:0] out;
        int          cyc;
    } vec_t;
    vec_t v [4];
    int passed = 0, total = 0;
    logic [15:0] cur_img [4];
    logic [15:0] cur_wei [4];
    logic [31:0] cur_base = '0;
    logic [31:0] img_off, wei_off;
    logic [31:0] img_log [256];
    logic [31:0] wei_log [256];
    int img_n = 0, wei_n = 0, img_stalls = 0, wei_stalls = 0, read_cyc = 0;
    int img_job0 = 0, wei_job0 = 0, img_stall0 = 0, wei_stall0 = 0, img_wait_cfg = 0, wei_wait_cfg = 0;

    always #5 clk = ~clk;

    neuron_mac_engine dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .kernel_size(kernel_size), .base_addr(base_addr),
        .done(done), .out_neuron(out_neuron), .addr_img(addr_img), .addr_wei(addr_wei),
        .img_read(img_read), .img_write(img_write), .img_address(img_address),
        .img_writedata(img_writedata), .img_readdata(img_readdata), .img_waitrequest(img_waitrequest),
        .wei_read(wei_read), .wei_write(wei_write), .wei_address(wei_address),
        .wei_writedata(wei_writedata), .wei_readdata(wei_readdata), .wei_waitrequest(wei_waitrequest)
    );

    // zero-latency memory model with junk in the upper data bits
    always_comb begin
        img_off = (img_address - cur_base) >> 2;
        wei_off = (wei_address - cur_base - OFF) >> 2;
        img_readdata = {16'hABCD, cur_img[img_off[1:0]]};
        wei_readdata = {16'h5A5A, cur_wei[wei_off[1:0]]};
    end
    assign img_waitrequest = img_read && img_n == img_job0 && img_stalls - img_stall0 < img_wait_cfg;
    assign wei_waitrequest = wei_read && wei_n == wei_job0 && wei_stalls - wei_stall0 < wei_wait_cfg;

    // bus monitor: logs accepted addresses and counts stall/read cycles
    always @(posedge clk) begin
        if (img_read && !img_waitrequest) begin
            img_log[img_n[7:0]] <= img_address;
            img_n <= img_n + 1;
        end
        if (wei_read && !wei_waitrequest) begin
            wei_log[wei_n[7:0]] <= wei_address;
            wei_n <= wei_n + 1;
        end
        if (img_read && img_waitrequest) img_stalls <= img_stalls + 1;
        if (wei_read && wei_waitrequest) wei_stalls <= wei_stalls + 1;
        if (img_read || wei_read) read_cyc <= read_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic setup(input int k);
        cur_base = v[k].base;
        cur_img = v[k].img;
        cur_wei = v[k].wei;
        img_job0 = img_n;
        wei_job0 = wei_n;
        img_stall0 = img_stalls;
        wei_stall0 = wei_stalls;
        img_wait_cfg = v[k].wimg;
        wei_wait_cfg = v[k].wwei;
        kernel_size = v[k].n;
        base_addr = v[k].base;
    endtask

    task automatic run_job(input int k, input int clr_cyc, input bit hold);
        int cnt, r0;
        @(negedge clk);
        setup(k);
        r0 = read_cyc;
        start = 1'b1;
        @(posedge clk);
        #1 cnt = 1;
        while (!done && cnt < 600) begin
            clear = cnt == clr_cyc;
            if (img_n == img_job0 && img_stalls - img_stall0 < img_wait_cfg) begin
                check($sformatf("v%0d_held_read", k), {31'd0, img_read}, 32'd1);
                check($sformatf("v%0d_held_addr", k), img_address, v[k].base);
            end
            @(posedge clk);
            #1 cnt++;
        end
        clear = 1'b0;
        check($sformatf("v%0d_done_cycle", k), cnt, v[k].cyc);
        check($sformatf("v%0d_out", k), out_neuron, v[k].out);
        check($sformatf("v%0d_img_reads", k), img_n - img_job0, {24'd0, v[k].n});
        check($sformatf("v%0d_wei_reads", k), wei_n - wei_job0, {24'd0, v[k].n});
        for (int j = 0; j < int'(v[k].n) && j < 4; j++) begin
            check($sformatf("v%0d_img_addr%0d", k, j), img_log[img_job0 + j], v[k].base + 32'(4 * j));
            check($sformatf("v%0d_wei_addr%0d", k, j), wei_log[wei_job0 + j], v[k].base + OFF + 32'(4 * j));
        end
        if (v[k].n == 8'd0) check($sformatf("v%0d_no_read", k), read_cyc - r0, 32'd0);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int r0;
        v[0].n = 8'd3; v[0].base = 32'h0000_1000;
        v[0].img = '{16'd2, 16'd3, 16'd4, 16'd0}; v[0].wei = '{16'd5, 16'd6, 16'd7, 16'd0};
        v[0].wimg = 0; v[0].wwei = 0; v[0].out = 32'd56; v[0].cyc = 7;
        v[1].n = 8'd2; v[1].base = 32'h0000_2000;
        v[1].img = '{16'hFFFD, 16'd100, 16'd0, 16'd0}; v[1].wei = '{16'd4, 16'hFFFE, 16'd0, 16'd0};
        v[1].wimg = 3; v[1].wwei = 0; v[1].out = 32'hFFFF_FF2C; v[1].cyc = 8;
        v[2].n = 8'd0; v[2].base = 32'h0000_3000;
        v[2].img = '{16'd9, 16'd9, 16'd9, 16'd9}; v[2].wei = '{16'd9, 16'd9, 16'd9, 16'd9};
        v[2].wimg = 0; v[2].wwei = 0; v[2].out = 32'd0; v[2].cyc = 1;
        v[3].n = 8'd4; v[3].base = 32'hFFFF_FFF8;
        v[3].img = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'd1000}; v[3].wei = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFC18};
        v[3].wimg = 0; v[3].wwei = 2; v[3].out = 32'd2146418114; v[3].cyc = 11;
        cur_img = v[0].img;
        cur_wei = v[0].wei;
        reset = 1'b1; start = 1'b0; clear = 1'b0; kernel_size = '0; base_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", out_neuron, 32'd0);
        check("rst_reads", {30'd0, img_read, wei_read}, 32'd0);
        check("rst_img_addr", img_address, 32'd0);
        check("rst_wei_addr", wei_address, 32'd0);
        check("rst_addr_dbg", addr_img | addr_wei, 32'd0);
        check("tied_writes", {30'd0, img_write, wei_write} | img_writedata | wei_writedata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) run_job(k, 0, 1'b0);
        // clear while DONE
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_done", {31'd0, done}, 32'd0);
        check("clear_out", out_neuron, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        // clear during a stalled FETCH is ignored
        run_job(1, 2, 1'b0);
        // start held high after a job must not relaunch
        run_job(0, 0, 1'b1);
        r0 = read_cyc;
        repeat (20) @(posedge clk);
        #1;
        check("hold_no_relaunch", read_cyc - r0, 32'd0);
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_out", out_neuron, 32'd56);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        run_job(0, 0, 1'b0);
        // clear and start edge together: clear wins
        @(negedge clk);
        r0 = read_cyc;
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("clr_vs_start_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("clr_vs_start_noread", read_cyc - r0, 32'd0);
        check("clr_vs_start_out", out_neuron, 32'd0);
        @(negedge clk);
        start = 1'b0;
        // reset in the middle of a stalled FETCH
        @(negedge clk);
        setup(0);
        img_wait_cfg = 10;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_fetch_read", {31'd0, img_read}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_reads", {30'd0, img_read, wei_read}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_addr", img_address | wei_address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_job(0, 0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
